blink_period_decoder: RTL and testbench

Receive-side counterpart of the bike-light blinker. Watches a single blink waveform and measures its high time, low time and full period in `count_en` beats (beat32 ticks). Reports the period's binary exponent so the shift level a blinker was programmed to can be recovered. Used for self-check of blinker outputs and for locking a second light to an observed blink rate.

---
 rtl/blink_pkg.sv | 14 +
 rtl/blink_period_decoder_if.sv | 29 ++
 rtl/blink_msb_encoder.sv | 19 +
 rtl/blink_period_decoder.sv | 131 +++++++++++++
 tb/tb_blink_period_decoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the blink period decoder.
package blink_pkg;

    localparam int unsigned BLINK_CNT_W   = 16;
    localparam int unsigned BLINK_SHIFT_W = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        STUCK     = 2'd3
    } blink_dec_state_t;

endpackage

// File: rtl/blink_period_decoder_if.sv
// Blink input plus measurement result bundle for the blink period decoder.
interface blink_period_decoder_if
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W   = BLINK_CNT_W,
    parameter int unsigned SHIFT_W = BLINK_SHIFT_W
);

    logic               count_en;
    logic               blink_in;
    logic [CNT_W-1:0]   high_ticks;
    logic [CNT_W-1:0]   low_ticks;
    logic [CNT_W:0]     period_ticks;
    logic [SHIFT_W-1:0] shift_level;
    logic               is_pow2;
    logic               valid;
    logic               stuck;

    modport master (
        output count_en, blink_in,
        input  high_ticks, low_ticks, period_ticks, shift_level, is_pow2, valid, stuck
    );

    modport slave (
        input  count_en, blink_in,
        output high_ticks, low_ticks, period_ticks, shift_level, is_pow2, valid, stuck
    );

endinterface

// File: rtl/blink_msb_encoder.sv
// Combinational MSB-index priority encoder with exact power-of-two flag.
module blink_msb_encoder #(
    parameter int unsigned IN_W    = 17,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic [IN_W-1:0]    i_value,
    output logic [SHIFT_W-1:0] o_msb_c,
    output logic               o_pow2_c
);

    always_comb begin
        o_msb_c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i_value[i]) o_msb_c = SHIFT_W'(i);
        end
        o_pow2_c = (i_value != '0) && ((i_value & (i_value - IN_W'(1))) == '0);
    end

endmodule

// File: rtl/blink_period_decoder.sv
// Measures high/low/period beat counts of a blink waveform and recovers its
// binary exponent; flags a waveform that stops toggling.
module blink_period_decoder
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W   = BLINK_CNT_W,
    parameter int unsigned SHIFT_W = BLINK_SHIFT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    blink_period_decoder_if.slave  io_blink
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    blink_dec_state_t   r_state;
    logic               r_prev;
    logic [CNT_W-1:0]   r_hi_cnt;
    logic [CNT_W-1:0]   r_lo_cnt;
    logic [CNT_W-1:0]   r_high_ticks;
    logic [CNT_W-1:0]   r_low_ticks;
    logic [CNT_W:0]     r_period;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_pow2;
    logic               r_valid;
    logic               r_stuck;

    logic               w_rise;
    logic               w_fall;
    logic [CNT_W-1:0]   w_load;
    logic [CNT_W-1:0]   w_hi_inc;
    logic [CNT_W-1:0]   w_lo_inc;
    logic [CNT_W:0]     w_period;
    logic [SHIFT_W-1:0] w_msb;
    logic               w_pow2;

    assign w_rise   =  io_blink.blink_in & ~r_prev;
    assign w_fall   = ~io_blink.blink_in &  r_prev;
    // A beat on the edge cycle belongs to the phase that is just starting.
    assign w_load   = CNT_W'(io_blink.count_en);
    assign w_hi_inc = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
    assign w_lo_inc = (r_lo_cnt == CNT_MAX) ? r_lo_cnt : r_lo_cnt + CNT_W'(1);
    assign w_period = (CNT_W+1)'(r_hi_cnt) + (CNT_W+1)'(r_lo_cnt);

    blink_msb_encoder #(
        .IN_W    (CNT_W + 1),
        .SHIFT_W (SHIFT_W)
    ) u_msb (
        .i_value  (w_period),
        .o_msb_c  (w_msb),
        .o_pow2_c (w_pow2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_prev       <= 1'b0;
            r_hi_cnt     <= '0;
            r_lo_cnt     <= '0;
            r_high_ticks <= '0;
            r_low_ticks  <= '0;
            r_period     <= '0;
            r_shift      <= '0;
            r_pow2       <= 1'b0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_prev  <= io_blink.blink_in;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state  <= MEAS_HIGH;
                        r_hi_cnt <= w_load;
                        r_lo_cnt <= '0;
                    end
                end
                MEAS_HIGH: begin
                    if (w_fall) begin
                        r_state  <= MEAS_LOW;
                        r_lo_cnt <= w_load;
                    end else if (io_blink.count_en) begin
                        r_hi_cnt <= w_hi_inc;
                        if (w_hi_inc == CNT_MAX) begin
                            r_state <= STUCK;
                            r_stuck <= 1'b1;
                        end
                    end
                end
                MEAS_LOW: begin
                    // Closing rise: publish the finished period and start the next one.
                    if (w_rise) begin
                        r_high_ticks <= r_hi_cnt;
                        r_low_ticks  <= r_lo_cnt;
                        r_period     <= w_period;
                        r_shift      <= w_msb;
                        r_pow2       <= w_pow2;
                        r_valid      <= 1'b1;
                        r_state      <= MEAS_HIGH;
                        r_hi_cnt     <= w_load;
                        r_lo_cnt     <= '0;
                    end else if (io_blink.count_en) begin
                        r_lo_cnt <= w_lo_inc;
                        if (w_lo_inc == CNT_MAX) begin
                            r_state <= STUCK;
                            r_stuck <= 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (w_rise) begin
                        r_stuck  <= 1'b0;
                        r_state  <= MEAS_HIGH;
                        r_hi_cnt <= w_load;
                        r_lo_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_blink.high_ticks   = r_high_ticks;
    assign io_blink.low_ticks    = r_low_ticks;
    assign io_blink.period_ticks = r_period;
    assign io_blink.shift_level  = r_shift;
    assign io_blink.is_pow2      = r_pow2;
    assign io_blink.valid        = r_valid;
    assign io_blink.stuck        = r_stuck;

endmodule

// File: tb/tb_blink_period_decoder.sv
// Directed bench for blink_period_decoder: a 16-bit and a 4-bit instance.
module tb_blink_period_decoder;
    import blink_pkg::*;

    logic clk;
    logic reset_n;
    logic sel;
    logic t_en;
    logic t_blk;
    int   n_vec;
    int   n_err;
    int   vcount;
    int   vb;

    blink_period_decoder_if #(.CNT_W(16), .SHIFT_W(5)) if16 ();
    blink_period_decoder_if #(.CNT_W(4),  .SHIFT_W(3)) if4  ();

    blink_period_decoder #(.CNT_W(16), .SHIFT_W(5)) dut16 (
        .clk      (clk),
        .reset_n  (reset_n),
        .io_blink (if16.slave)
    );

    blink_period_decoder #(.CNT_W(4), .SHIFT_W(3)) dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .io_blink (if4.slave)
    );

    assign if16.count_en = sel ? 1'b0 : t_en;
    assign if16.blink_in = sel ? 1'b0 : t_blk;
    assign if4.count_en  = sel ? t_en  : 1'b0;
    assign if4.blink_in  = sel ? t_blk : 1'b0;

    logic [31:0] o_hi, o_lo, o_per, o_sh;
    logic        o_p2, o_v, o_st;

    always_comb begin
        if (sel) begin
            o_hi  = 32'(if4.high_ticks);
            o_lo  = 32'(if4.low_ticks);
            o_per = 32'(if4.period_ticks);
            o_sh  = 32'(if4.shift_level);
            o_p2  = if4.is_pow2;
            o_v   = if4.valid;
            o_st  = if4.stuck;
        end else begin
            o_hi  = 32'(if16.high_ticks);
            o_lo  = 32'(if16.low_ticks);
            o_per = 32'(if16.period_ticks);
            o_sh  = 32'(if16.shift_level);
            o_p2  = if16.is_pow2;
            o_v   = if16.valid;
            o_st  = if16.stuck;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial vcount = 0;
    always @(posedge clk) if (o_v) vcount = vcount + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_meas(input string tag, input int hi, input int lo,
                              input int per, input int sh, input logic p2);
        check({tag, "_valid"},  32'(o_v),  32'd1);
        check({tag, "_high"},   o_hi,      32'(hi));
        check({tag, "_low"},    o_lo,      32'(lo));
        check({tag, "_period"}, o_per,     32'(per));
        check({tag, "_shift"},  o_sh,      32'(sh));
        check({tag, "_pow2"},   32'(o_p2), 32'(p2));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high"},   o_hi,      32'd0);
        check({tag, "_low"},    o_lo,      32'd0);
        check({tag, "_period"}, o_per,     32'd0);
        check({tag, "_shift"},  o_sh,      32'd0);
        check({tag, "_pow2"},   32'(o_p2), 32'd0);
        check({tag, "_valid"},  32'(o_v),  32'd0);
        check({tag, "_stuck"},  32'(o_st), 32'd0);
    endtask

    task automatic cyc(input logic en, input logic b);
        t_en  = en;
        t_blk = b;
        @(posedge clk);
        #1;
    endtask

    // One non-counted cycle at level b, then n beats spaced gap clocks apart.
    task automatic phase(input logic b, input int n, input int gap);
        cyc(1'b0, b);
        repeat (n) begin
            repeat (gap - 1) cyc(1'b0, b);
            cyc(1'b1, b);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        sel     = 1'b0;
        t_en    = 1'b0;
        t_blk   = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset16");
        check("reset16_state", 32'(dut16.r_state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);

        // 3 high / 3 low, beat every 10 clocks
        vb = vcount;
        phase(1'b1, 3, 10);
        phase(1'b0, 3, 10);
        check("t1_no_early_valid", 32'(vcount - vb), 32'd0);
        cyc(1'b0, 1'b1);
        check_meas("t1", 3, 3, 6, 2, 1'b0);
        cyc(1'b0, 1'b1);
        check("t1_pulse_width", 32'(o_v), 32'd0);
        check("t1_hold_high", o_hi, 32'd3);

        // 4 high / 4 low repeating: one valid per period
        phase(1'b1, 4, 3);
        phase(1'b0, 4, 3);
        cyc(1'b0, 1'b1);
        check_meas("t2a", 4, 4, 8, 3, 1'b1);
        vb = vcount;
        phase(1'b1, 4, 3);
        phase(1'b0, 4, 3);
        cyc(1'b0, 1'b1);
        check_meas("t2b", 4, 4, 8, 3, 1'b1);
        cyc(1'b0, 1'b1);
        check("t2_valid_count", 32'(vcount - vb), 32'd2);

        // closing rise coincides with a beat: beat goes to the new high phase
        phase(1'b1, 2, 3);
        phase(1'b0, 3, 3);
        cyc(1'b1, 1'b1);
        check_meas("t3a", 2, 3, 5, 2, 1'b0);
        repeat (4) begin
            repeat (2) cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1);
        end
        phase(1'b0, 3, 3);
        cyc(1'b0, 1'b1);
        check_meas("t3b", 5, 3, 8, 3, 1'b1);

        // zero-length period, then a one-cycle glitch high
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check_meas("t4_zero", 0, 0, 0, 0, 1'b0);
        cyc(1'b0, 1'b0);
        phase(1'b0, 2, 3);
        cyc(1'b0, 1'b1);
        check_meas("t4_glitch", 0, 2, 2, 1, 1'b1);

        // asynchronous reset in MEAS_LOW
        phase(1'b1, 2, 3);
        phase(1'b0, 2, 3);
        check("t5_pre_state", 32'(dut16.r_state), 32'(MEAS_LOW));
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("t5_async");
        check("t5_state", 32'(dut16.r_state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        vb = vcount;
        phase(1'b1, 2, 3);
        phase(1'b0, 2, 3);
        check("t5_no_valid", 32'(vcount - vb), 32'd0);
        check("t5_high_still0", o_hi, 32'd0);
        cyc(1'b0, 1'b1);
        check_meas("t5", 2, 2, 4, 2, 1'b1);

        // low-only input after reset stays idle
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        vb = vcount;
        repeat (10) cyc(1'b0, 1'b0);
        phase(1'b0, 4, 3);
        check("t6_no_valid", 32'(vcount - vb), 32'd0);
        check("t6_state", 32'(dut16.r_state), 32'(IDLE));
        check("t6_period", o_per, 32'd0);

        // 4-bit instance: saturation and recovery
        sel = 1'b1;
        cyc(1'b0, 1'b0);
        check_zero("t7_init");
        phase(1'b1, 2, 2);
        phase(1'b0, 1, 2);
        cyc(1'b0, 1'b1);
        check_meas("t7a", 2, 1, 3, 1, 1'b0);
        repeat (14) begin
            cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1);
        end
        check("t7_not_yet_stuck", 32'(o_st), 32'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        check("t7_stuck_hi", 32'(o_st), 32'd1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        check("t7_stuck_hold", 32'(o_st), 32'd1);
        check("t7_hold_high", o_hi, 32'd2);
        check("t7_hold_low", o_lo, 32'd1);
        check("t7_hold_period", o_per, 32'd3);
        vb = vcount;
        phase(1'b0, 2, 2);
        check("t7_fall_ignored", 32'(o_st), 32'd1);
        cyc(1'b0, 1'b1);
        check("t7_release", 32'(o_st), 32'd0);
        check("t7_release_novalid", 32'(o_v), 32'd0);
        phase(1'b1, 3, 2);
        phase(1'b0, 2, 2);
        check("t7_no_valid", 32'(vcount - vb), 32'd0);
        cyc(1'b0, 1'b1);
        check_meas("t7b", 3, 2, 5, 2, 1'b0);

        // low-phase saturation
        phase(1'b0, 14, 2);
        check("t8_not_yet_stuck", 32'(o_st), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("t8_stuck_lo", 32'(o_st), 32'd1);
        cyc(1'b0, 1'b1);
        check("t8_release", 32'(o_st), 32'd0);
        check("t8_release_novalid", 32'(o_v), 32'd0);
        check("t8_hold_high", o_hi, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
